fft_out_reorder: RTL and testbench

//  Output reorder buffer for the 32-point radix-2 MDC FFT; sits directly after the final MDC stage.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_reorder_bank.sv | 30 +++
 rtl/fft_out_reorder.sv | 146 ++++++++++++++
 tb/tb_fft_out_reorder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and index helpers for the 32-point MDC FFT output reorder path.
package fft_pkg;

  localparam int DATA_W  = 9;
  localparam int LOG2N   = 5;
  localparam int AW      = LOG2N - 1;
  localparam int HALF    = 1 << AW;
  localparam int ENTRY_W = 4 * DATA_W;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // One bank entry holds the Up lane pair (MSBs) and the Down lane pair.
  typedef struct packed {
    cplx_t up;
    cplx_t dn;
  } entry_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: HALF x ENTRY_W register file, one synchronous write port, one asynchronous read port.
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [HALF];
  logic [ENTRY_W-1:0] mem_d [HALF];

  // Next-state of the storage array: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      mem_d[i] = (we && (waddr == AW'(i))) ? wdata : mem_q[i];
    end
  end

  // Storage is intentionally left unreset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Output reorder buffer: writes bit-reversed dual-lane FFT results into ping-pong banks and
// streams each completed frame back out in natural order with no gaps between frames.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic [DATA_W-1:0] in_up_re,
  input  logic [DATA_W-1:0] in_up_im,
  input  logic [DATA_W-1:0] in_dn_re,
  input  logic [DATA_W-1:0] in_dn_im,
  output logic              out_valid,
  output logic              out_first,
  output logic [DATA_W-1:0] out_up_re,
  output logic [DATA_W-1:0] out_up_im,
  output logic [DATA_W-1:0] out_dn_re,
  output logic [DATA_W-1:0] out_dn_im,
  output logic              frame_err
);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic          rd_active_q, rd_active_d;
  logic          frame_err_q, frame_err_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  entry_t        out_data_q, out_data_d;

  entry_t             wr_data_s;
  entry_t             rd_data_s;
  logic [AW-1:0]      wr_addr_s;
  logic               complete_s;
  logic               we0_s, we1_s;
  logic [ENTRY_W-1:0] rd_data0_s, rd_data1_s;

  assign wr_data_s  = {in_up_re, in_up_im, in_dn_re, in_dn_im};
  assign wr_addr_s  = in_first ? 4'd0 : bitrev4(wr_cnt_q);
  // A restart via in_first never completes a frame, even if wr_cnt_q happens to be 15.
  assign complete_s = in_valid & ~in_first & (wr_cnt_q == 4'd15);
  assign we0_s      = in_valid & ~wr_bank_q;
  assign we1_s      = in_valid &  wr_bank_q;
  assign rd_data_s  = rd_bank_q ? rd_data1_s : rd_data0_s;

  fft_reorder_bank u_bank0 (
    .clk   (clk),
    .we    (we0_s),
    .waddr (wr_addr_s),
    .wdata (wr_data_s),
    .raddr (rd_cnt_q),
    .rdata (rd_data0_s)
  );

  fft_reorder_bank u_bank1 (
    .clk   (clk),
    .we    (we1_s),
    .waddr (wr_addr_s),
    .wdata (wr_data_s),
    .raddr (rd_cnt_q),
    .rdata (rd_data1_s)
  );

  // Write-side control: frame counter, restart detection and bank swap on completion.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    frame_err_d = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        wr_cnt_d    = 4'd1;
        frame_err_d = (wr_cnt_q != 4'd0);
      end else begin
        wr_cnt_d    = wr_cnt_q + 4'd1;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (complete_s) begin
      wr_bank_d = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
  end

  // Read-side control: a completion always (re)starts the read so consecutive frames abut.
  always_comb begin
    if (rd_active_q) begin
      out_valid_d = 1'b1;
      out_first_d = (rd_cnt_q == 4'd0);
      out_data_d  = rd_data_s;
    end else begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_data_d  = out_data_q;
    end
    if (complete_s) begin
      rd_bank_d   = wr_bank_q;
      rd_cnt_d    = 4'd0;
      rd_active_d = 1'b1;
    end else if (rd_active_q) begin
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q + 4'd1;
      rd_active_d = (rd_cnt_q != 4'd15);
    end else begin
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      rd_active_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= 4'd0;
      wr_bank_q   <= 1'b0;
      rd_cnt_q    <= 4'd0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_data_q  <= {ENTRY_W{1'b0}};
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_up_re = out_data_q.up.re;
  assign out_up_im = out_data_q.up.im;
  assign out_dn_re = out_data_q.dn.re;
  assign out_dn_im = out_data_q.dn.im;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench: frames X[0..31] are fed in bit-reversed lane order and expected back in natural order.
module tb_fft_out_reorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_first = 1'b0;
  logic [8:0] in_up_re = 9'd0;
  logic [8:0] in_up_im = 9'd0;
  logic [8:0] in_dn_re = 9'd0;
  logic [8:0] in_dn_im = 9'd0;
  logic       out_valid, out_first, frame_err;
  logic [8:0] out_up_re, out_up_im, out_dn_re, out_dn_im;

  fft_out_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_up_re  (in_up_re),
    .in_up_im  (in_up_im),
    .in_dn_re  (in_dn_re),
    .in_dn_im  (in_dn_im),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_up_re (out_up_re),
    .out_up_im (out_up_im),
    .out_dn_re (out_dn_re),
    .out_dn_im (out_dn_im),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       first;
    logic [8:0] ur, ui, dr, di;
  } exp_t;

  exp_t       eq[$];
  logic [8:0] xr[32];
  logic [8:0] xi[32];
  logic [8:0] last_ur = 9'd0, last_ui = 9'd0, last_dr = 9'd0, last_di = 9'd0;
  logic       exp_ferr = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  function automatic int brev(input int c);
    int r = 0;
    int v = c;
    for (int i = 0; i < 4; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // mode 0: X[k].re = k + add, im random; mode 1: fully random frame
  task automatic gen_frame(input int mode, input int add);
    for (int k = 0; k < 32; k++) begin
      xr[k] = (mode == 0) ? 9'(k + add) : 9'($urandom);
      xi[k] = 9'($urandom);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic ev;
    @(posedge clk);
    #1;
    cyc++;
    ev = (eq.size() > 0) && (eq[0].cyc == cyc);
    chk("out_valid", out_valid, ev);
    chk("frame_err", frame_err, exp_ferr);
    exp_ferr = 1'b0;
    if (ev) begin
      e = eq.pop_front();
      chk("out_first", out_first, e.first);
      chk("out_up_re", out_up_re, e.ur);
      chk("out_up_im", out_up_im, e.ui);
      chk("out_dn_re", out_dn_re, e.dr);
      chk("out_dn_im", out_dn_im, e.di);
      last_ur = e.ur; last_ui = e.ui; last_dr = e.dr; last_di = e.di;
    end else begin
      chk("idle_first", out_first, 1'b0);
      chk("hold_up_re", out_up_re, last_ur);
      chk("hold_up_im", out_up_im, last_ui);
      chk("hold_dn_re", out_dn_re, last_dr);
      chk("hold_dn_im", out_dn_im, last_di);
    end
  endtask

  // gap_mode 0: contiguous, 1: one idle cycle after each pair, 2: random 0..2 idle cycles
  task automatic send_frame(input int gap_mode, input int n_pairs, input logic err_first);
    exp_t e;
    int   g;
    for (int c = 0; c < n_pairs; c++) begin
      in_valid = 1'b1;
      in_first = (c == 0);
      in_up_re = xr[brev(c)];
      in_up_im = xi[brev(c)];
      in_dn_re = xr[16 + brev(c)];
      in_dn_im = xi[16 + brev(c)];
      exp_ferr = (c == 0) && err_first;
      tick();
      if (c == 15) begin
        for (int m = 0; m < 16; m++) begin
          e.cyc = cyc + 1 + m;
          e.first = (m == 0);
          e.ur = xr[m]; e.ui = xi[m]; e.dr = xr[m + 16]; e.di = xi[m + 16];
          eq.push_back(e);
        end
      end
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_first = 1'($urandom);
        in_up_re = 9'($urandom);
        in_dn_re = 9'($urandom);
        tick();
      end
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state.
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Counting pattern, contiguous; latency and trailing low cycle come from the schedule.
    gen_frame(0, 0);
    send_frame(0, 16, 1'b0);
    idle(20);

    // Two back-to-back frames, the second offset by 64.
    gen_frame(0, 0);
    send_frame(0, 16, 1'b0);
    gen_frame(0, 64);
    send_frame(0, 16, 1'b0);
    idle(20);

    // Alternating in_valid gaps.
    gen_frame(1, 0);
    send_frame(1, 16, 1'b0);
    idle(20);

    // Restart at c=7: partial frame discarded, next frame intact.
    gen_frame(1, 0);
    send_frame(0, 7, 1'b0);
    gen_frame(1, 0);
    send_frame(0, 16, 1'b1);
    idle(20);

    // Random gaps, then a contiguous frame right behind.
    gen_frame(1, 0);
    send_frame(2, 16, 1'b0);
    gen_frame(1, 0);
    send_frame(0, 16, 1'b0);
    idle(20);

    // Asynchronous reset while m=5 is on the outputs.
    gen_frame(1, 0);
    send_frame(0, 16, 1'b0);
    idle(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_up_re", out_up_re, 9'd0);
    chk("rst_out_dn_im", out_dn_im, 9'd0);
    eq.delete();
    last_ur = 9'd0; last_ui = 9'd0; last_dr = 9'd0; last_di = 9'd0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    gen_frame(1, 0);
    send_frame(0, 16, 1'b0);
    idle(20);

    chk("queue_drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
